// File: rtl/lap_recorder_pkg.sv
// Shared widths, lap entry payload and FSM state type for the lap recorder.
package lap_pkg;

  localparam int unsigned HOUR_W  = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MSEC_W  = 7;
  localparam int unsigned ENTRY_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

  // One stored split, MSB-first hour..centiseconds
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [MSEC_W-1:0] m_sec;
  } lap_entry_t;

  typedef enum logic [1:0] {
    LIVE,
    HOLD,
    RECALL
  } lap_state_t;

endpackage

// File: rtl/lap_recorder_if.sv
// Bundles the stopwatch-side inputs and display-side outputs of lap_recorder.
//   master: drives run/lap/clear and live time, observes display and status
//   slave : the recorder itself
interface lap_recorder_if #(
  parameter int unsigned DEPTH = 8
);
  import lap_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              run;
  logic              lap;
  logic              clear;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  minute;
  logic [SEC_W-1:0]  second;
  logic [MSEC_W-1:0] m_sec;
  logic [HOUR_W-1:0] disp_hour;
  logic [MIN_W-1:0]  disp_minute;
  logic [SEC_W-1:0]  disp_second;
  logic [MSEC_W-1:0] disp_m_sec;
  logic [CNT_W-1:0]  lap_count;
  logic [CNT_W-1:0]  lap_index;
  logic              showing_lap;
  logic              full;

  modport master (
    output run, lap, clear, hour, minute, second, m_sec,
    input  disp_hour, disp_minute, disp_second, disp_m_sec,
           lap_count, lap_index, showing_lap, full
  );

  modport slave (
    input  run, lap, clear, hour, minute, second, m_sec,
    output disp_hour, disp_minute, disp_second, disp_m_sec,
           lap_count, lap_index, showing_lap, full
  );

endinterface

// File: rtl/lap_recorder_buffer.sv
// Circular store of lap splits with write pointer, saturating count and wrap flag.
//   clock, reset : clock, async active-high reset
//   wr_en, clr   : append wr_data / forget all entries (clr wins)
//   rd_ptr       : combinational read address -> rd_data
//   wr_ptr, count, full : registered buffer status
module lap_buffer
  import lap_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       clr,
  input  lap_entry_t                 wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output lap_entry_t                 rd_data,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lap_entry_t mem [DEPTH];

  // Entry storage; contents survive clear, only the bookkeeping is reset
  always_ff @(posedge clock) begin
    if (wr_en && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer wraps naturally because DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count == CNT_W'(DEPTH)) begin
        full <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/lap_recorder.sv
// Chooses what the 7-segment chain shows: live time, a freshly held split, or a
// recalled lap. Records splits on lap presses while running.
//   clock, reset : 50 MHz clock, async active-high reset
//   bus (slave)  : run/lap/clear levels, live time in; disp_*, lap_count,
//                  lap_index, showing_lap, full out (all registered)
module lap_recorder
  import lap_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input logic           clock,
  input logic           reset,
  lap_recorder_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  lap_state_t        state, state_nxt;
  logic              lap_r, lap_d, clr_r, clr_d, run_d;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  lap_entry_t        held, held_nxt;
  lap_entry_t        disp, disp_nxt;
  logic [CNT_W-1:0]  index, index_nxt;
  logic              showing;

  logic              lap_edge, clr_edge, run_rise;
  logic              wr_en, buf_clr;
  lap_entry_t        live, rd_data;
  logic [PTR_W-1:0]  wr_ptr, oldest, newest, rel_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;

  lap_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .clr     (buf_clr),
    .wr_data (live),
    .rd_ptr  (rd_ptr_nxt),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr),
    .count   (count),
    .full    (full)
  );

  assign live     = '{hour: bus.hour, minute: bus.minute, second: bus.second, m_sec: bus.m_sec};
  assign lap_edge = lap_r & ~lap_d;
  assign clr_edge = clr_r & ~clr_d;
  assign run_rise = bus.run & ~run_d;
  // Once wrapped, the slot about to be overwritten holds the oldest split
  assign oldest   = full ? wr_ptr : '0;
  assign newest   = wr_ptr - PTR_W'(1);

  // State, edge-detect and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= LIVE;
      lap_r   <= 1'b0;
      lap_d   <= 1'b0;
      clr_r   <= 1'b0;
      clr_d   <= 1'b0;
      run_d   <= 1'b0;
      rd_ptr  <= '0;
      hold    <= '0;
      held    <= '0;
      disp    <= '0;
      index   <= '0;
      showing <= 1'b0;
    end else begin
      state   <= state_nxt;
      lap_r   <= bus.lap;
      lap_d   <= lap_r;
      clr_r   <= bus.clear;
      clr_d   <= clr_r;
      run_d   <= bus.run;
      rd_ptr  <= rd_ptr_nxt;
      hold    <= hold_nxt;
      held    <= held_nxt;
      disp    <= disp_nxt;
      index   <= index_nxt;
      showing <= (state_nxt != LIVE);
    end
  end

  // Next state; clear outranks everything, including a coincident lap edge
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    hold_nxt   = hold;
    held_nxt   = held;
    wr_en      = 1'b0;
    buf_clr    = 1'b0;
    if (clr_edge) begin
      buf_clr   = 1'b1;
      state_nxt = LIVE;
    end else begin
      case (state)
        LIVE: begin
          if (lap_edge && bus.run) begin
            wr_en     = 1'b1;
            held_nxt  = live;
            hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
            state_nxt = HOLD;
          end else if (lap_edge && count != '0) begin
            rd_ptr_nxt = oldest;
            state_nxt  = RECALL;
          end
        end
        HOLD: begin
          if (lap_edge && bus.run) begin
            wr_en    = 1'b1;
            held_nxt = live;
            hold_nxt = HOLD_W'(HOLD_CYCLES - 1);
          end else if (hold == '0) begin
            state_nxt = LIVE;
          end else begin
            hold_nxt = hold - HOLD_W'(1);
          end
        end
        RECALL: begin
          if (run_rise) begin
            state_nxt = LIVE;
          end else if (lap_edge) begin
            if (rd_ptr == newest) begin
              state_nxt = LIVE;
            end else begin
              rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
          end
        end
        default: state_nxt = LIVE;
      endcase
    end
  end

  // Display mux is evaluated on the next state so outputs stay registered
  always_comb begin
    rel_ptr   = rd_ptr_nxt - oldest;
    disp_nxt  = live;
    index_nxt = '0;
    case (state_nxt)
      HOLD:    disp_nxt = held_nxt;
      RECALL: begin
        disp_nxt  = rd_data;
        index_nxt = CNT_W'(rel_ptr) + CNT_W'(1);
      end
      default: disp_nxt = live;
    endcase
  end

  assign bus.disp_hour   = disp.hour;
  assign bus.disp_minute = disp.minute;
  assign bus.disp_second = disp.second;
  assign bus.disp_m_sec  = disp.m_sec;
  assign bus.lap_count   = count;
  assign bus.lap_index   = index;
  assign bus.showing_lap = showing;
  assign bus.full        = full;

endmodule
